// File: rtl/vga_pkg.sv
// Default pong VGA timing, derived totals/widths and the shared colour type.
package vga_pkg;

  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_H_SYNC  = 48;
  localparam int DEF_H_BACK  = 2;
  localparam int DEF_H_ACT   = 700;
  localparam int DEF_H_FRONT = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 3;
  localparam int DEF_V_ACT   = 500;
  localparam int DEF_V_FRONT = 10;

  localparam int H_TOT = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACT + DEF_H_FRONT;
  localparam int V_TOT = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACT + DEF_V_FRONT;
  localparam int H_W   = $clog2(H_TOT);
  localparam int V_W   = $clog2(V_TOT);

  typedef logic [2:0] rgb3_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts the SYNC, BACK, ACT, FRONT segments in order and wraps
// back to the start of SYNC after the last FRONT position.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int SYNC  = DEF_H_SYNC,
  parameter int BACK  = DEF_H_BACK,
  parameter int ACT   = DEF_H_ACT,
  parameter int FRONT = DEF_H_FRONT,
  parameter int W     = $clog2(SYNC + BACK + ACT + FRONT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_sync,
  output logic         in_act
);

  localparam int TOT = SYNC + BACK + ACT + FRONT;
  localparam logic [W-1:0] LAST    = W'(TOT - 1);
  // One extra bit so segment ends equal to 2**W still compare correctly.
  localparam logic [W:0]   SYNC_END = (W+1)'(SYNC);
  localparam logic [W:0]   ACT_BEG  = (W+1)'(SYNC + BACK);
  localparam logic [W:0]   ACT_END  = (W+1)'(SYNC + BACK + ACT);

  logic [W-1:0] cnt_reg;
  logic         at_last;

  assign at_last = (cnt_reg == LAST);
  assign wrap    = en && at_last;
  assign cnt     = cnt_reg;
  assign in_sync = ({1'b0, cnt_reg} < SYNC_END);
  assign in_act  = ({1'b0, cnt_reg} >= ACT_BEG) && ({1'b0, cnt_reg} < ACT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= at_last ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster transmitter for the pong display: pixel-phase divider, horizontal and
// vertical segment counters, renderer request strobe and a single aligned output stage.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int H_ACT   = DEF_H_ACT,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int V_FRONT = DEF_V_FRONT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  input  logic [2:0]  pix_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  rgb,
  output logic        de,
  output logic        frame_start
);

  localparam int LINE_PIX    = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int FRAME_LINES = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int HW = (LINE_PIX == H_TOT) ? H_W : $clog2(LINE_PIX);
  localparam int VW = (FRAME_LINES == V_TOT) ? V_W : $clog2(FRAME_LINES);
  localparam int PW = $clog2(CLK_DIV);

  localparam logic [PW-1:0] P_LAST     = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P_REQ      = PW'(CLK_DIV - 2);
  localparam logic [HW-1:0] H_BP_START = HW'(H_SYNC);
  // Requests are issued during the pixel before the one being requested.
  localparam logic [HW:0]   H_REQ_LO   = (HW+1)'(H_SYNC + H_BACK - 1);
  localparam logic [HW:0]   H_REQ_HI   = (HW+1)'(H_SYNC + H_BACK + H_ACT - 1);
  localparam logic [10:0]   PIX_X_OFS  = 11'(H_SYNC + H_BACK - 1);
  localparam logic [9:0]    PIX_Y_OFS  = 10'(V_SYNC + V_BACK);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be at least 2");
    end
  endgenerate

  logic [PW-1:0] p_reg;
  logic          p_wrap;
  logic          p_first;
  logic [HW-1:0] h_cnt;
  logic          h_wrap;
  logic          h_in_sync;
  logic          h_in_act;
  logic [VW-1:0] v_cnt;
  logic          v_wrap_unused;
  logic          v_in_sync;
  logic          v_in_act;
  logic          h_next_act;
  logic          req_now;

  logic          hsync_reg;
  logic          vsync_reg;
  logic          de_reg;
  logic          frame_start_reg;
  logic          pix_req_reg;
  logic [10:0]   pix_x_reg;
  logic [9:0]    pix_y_reg;
  rgb3_t         rgb_reg;

  assign p_wrap  = (p_reg == P_LAST);
  assign p_first = (p_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      p_reg <= '0;
    end else begin
      p_reg <= p_wrap ? '0 : p_reg + 1'b1;
    end
  end

  vga_axis_counter #(
    .SYNC (H_SYNC),
    .BACK (H_BACK),
    .ACT  (H_ACT),
    .FRONT(H_FRONT),
    .W    (HW)
  ) u_h_axis (
    .clk    (clk),
    .reset  (reset),
    .en     (p_wrap),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .in_sync(h_in_sync),
    .in_act (h_in_act)
  );

  vga_axis_counter #(
    .SYNC (V_SYNC),
    .BACK (V_BACK),
    .ACT  (V_ACT),
    .FRONT(V_FRONT),
    .W    (VW)
  ) u_v_axis (
    .clk    (clk),
    .reset  (reset),
    .en     (h_wrap),
    .cnt    (v_cnt),
    .wrap   (v_wrap_unused),
    .in_sync(v_in_sync),
    .in_act (v_in_act)
  );

  assign h_next_act = ({1'b0, h_cnt} >= H_REQ_LO) && ({1'b0, h_cnt} < H_REQ_HI);
  assign req_now    = (p_reg == P_REQ) && h_next_act && v_in_act;

  // Every pin is registered from the same counter state, so they all move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_reg       <= 1'b0;
      vsync_reg       <= 1'b0;
      de_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
      pix_req_reg     <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      rgb_reg         <= '0;
    end else begin
      hsync_reg       <= h_in_sync;
      de_reg          <= h_in_act && v_in_act;
      frame_start_reg <= p_first && (h_cnt == '0) && (v_cnt == '0);
      pix_req_reg     <= req_now;
      pix_x_reg       <= req_now ? 11'(h_cnt) - PIX_X_OFS : '0;
      pix_y_reg       <= req_now ? 10'(v_cnt) - PIX_Y_OFS : '0;
      // vsync only toggles at the start of the horizontal back porch.
      if (p_first && (h_cnt == H_BP_START)) begin
        vsync_reg <= v_in_sync;
      end
      if (p_first) begin
        rgb_reg <= (h_in_act && v_in_act) ? pix_rgb : '0;
      end
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign frame_start = frame_start_reg;
  assign pix_req     = pix_req_reg;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign rgb         = rgb_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (17 pixels x 11 lines, 2 clks/pixel)
// with a renderer that answers each request with pix_x^pix_y.
module tb_vga_timing_gen;

  localparam int LINE_CLKS  = 34;
  localparam int FRAME_CLKS = 374;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  pix_rgb = 3'b000;
  logic        pix_req;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic        de;
  logic        frame_start;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int cyc = 0;
  int sync_err, de_err, rgb_err, req_err, order_err, vedge_err, fs_err;
  int hs_last_rise, hs_period, hs_width, vs_last_rise, vs_period, vs_width;
  int n_vs_rise, n_fs, n_req, n_white, req_idx;
  logic       prev_hs = 1'b0;
  logic       prev_vs = 1'b0;
  logic       req_q = 1'b0;
  logic [2:0] val_q = 3'b000;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(2), .H_SYNC(4), .H_BACK(2), .H_ACT(8), .H_FRONT(3),
    .V_SYNC(2), .V_BACK(3), .V_ACT(4), .V_FRONT(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_req    (pix_req),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .de         (de),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %s: got %0d want %0d", tag, obs, exp);
    end else begin
      failed++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    sync_err = 0; de_err = 0; rgb_err = 0; req_err = 0; order_err = 0;
    vedge_err = 0; fs_err = 0; n_vs_rise = 0; n_fs = 0; n_req = 0; n_white = 0;
    hs_last_rise = -1; hs_period = -1; hs_width = -1;
    vs_last_rise = -1; vs_period = -1; vs_width = -1;
  endtask

  // Advance n clks; cyc indexes clks since reset release (index 0 = first clk after release).
  task automatic step(input int n, input bit white);
    int h, v, f;
    logic e_hs, e_vs, e_de, e_fs, e_req;
    logic [10:0] e_px;
    logic [9:0]  e_py;
    logic [2:0]  e_rgb;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      h = (cyc / 2) % 17;
      v = (cyc / LINE_CLKS) % 11;
      f = cyc % FRAME_CLKS;
      e_hs  = (h < 4);
      e_vs  = (f >= 8) && (f < 8 + 2 * LINE_CLKS);
      e_fs  = (f == 0);
      e_de  = (h >= 6) && (h < 14) && (v >= 5) && (v < 9);
      e_req = (cyc % 2 == 0) && (h + 1 >= 6) && (h + 1 < 14) && (v >= 5) && (v < 9);
      e_px  = e_req ? 11'(h + 1 - 6) : 11'd0;
      e_py  = e_req ? 10'(v - 5) : 10'd0;
      e_rgb = !e_de ? 3'b000 : (white ? 3'b111 : 3'((h - 6) ^ (v - 5)));
      if ({hsync, vsync, frame_start} !== {e_hs, e_vs, e_fs}) sync_err++;
      if (de !== e_de) de_err++;
      if (rgb !== e_rgb) rgb_err++;
      if ({pix_req, pix_x, pix_y} !== {e_req, e_px, e_py}) req_err++;
      if (pix_req === 1'b1) begin
        if (pix_x !== 11'(req_idx % 8) || pix_y !== 10'((req_idx / 8) % 4)) order_err++;
        req_idx++;
        n_req++;
      end
      if (hsync === 1'b1 && prev_hs === 1'b0) begin
        if (hs_last_rise >= 0) hs_period = cyc - hs_last_rise;
        hs_last_rise = cyc;
      end
      if (hsync === 1'b0 && prev_hs === 1'b1) hs_width = cyc - hs_last_rise;
      if (vsync !== prev_vs) begin
        if (hsync !== 1'b0 || cyc - hs_last_rise != 8) vedge_err++;
        if (vsync === 1'b1) begin
          if (vs_last_rise >= 0) vs_period = cyc - vs_last_rise;
          vs_last_rise = cyc;
          n_vs_rise++;
        end else begin
          vs_width = cyc - vs_last_rise;
        end
      end
      if (frame_start === 1'b1) begin
        n_fs++;
        if (!(hsync === 1'b1 && prev_hs === 1'b0)) fs_err++;
      end
      if (white && rgb === 3'b111) n_white++;
      // Renderer answers one clk after the request; any other time it drives noise.
      if (white) pix_rgb = 3'b111;
      else pix_rgb = req_q ? val_q : 3'($urandom);
      req_q = (pix_req === 1'b1);
      val_q = pix_x[2:0] ^ pix_y[2:0];
      prev_hs = hsync;
      prev_vs = vsync;
      cyc++;
    end
  endtask

  initial begin
    clear_stats();
    req_idx = 0;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset_all_zero", 32'({pix_req, hsync, vsync, de, frame_start, rgb, pix_x, pix_y}), 0);
    reset = 1'b0;
    cyc = 0;

    step(1, 1'b0);
    check("release_frame_start", frame_start, 1);
    check("release_hsync", hsync, 1);
    check("release_vsync", vsync, 0);
    step(7, 1'b0);
    check("clk7_hsync", hsync, 1);
    check("clk7_vsync", vsync, 0);
    step(1, 1'b0);
    check("clk8_hsync", hsync, 0);
    check("clk8_vsync", vsync, 1);
    step(2 * FRAME_CLKS - 9, 1'b0);

    check("hsync_period", hs_period, LINE_CLKS);
    check("hsync_width", hs_width, 8);
    check("vsync_period", vs_period, FRAME_CLKS);
    check("vsync_width", vs_width, 2 * LINE_CLKS);
    check("vsync_rises", n_vs_rise, 2);
    check("vsync_edge_align_errs", vedge_err, 0);
    check("frame_start_count", n_fs, 2);
    check("frame_start_align_errs", fs_err, 0);
    check("pix_req_count", n_req, 64);
    check("raster_order_errs", order_err, 0);
    check("sync_model_errs", sync_err, 0);
    check("de_model_errs", de_err, 0);
    check("image_errs", rgb_err, 0);
    check("req_model_errs", req_err, 0);

    clear_stats();
    step(FRAME_CLKS, 1'b1);
    check("white_rgb_errs", rgb_err, 0);
    check("white_de_errs", de_err, 0);
    check("white_pixel_clks", n_white, 64);

    // Park on line 7 (active), pixel 3, second clk of the pixel, then pulse reset.
    step(7 * LINE_CLKS + 2 * 9 + 1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midline_reset_zero", 32'({pix_req, hsync, vsync, de, frame_start, rgb, pix_x, pix_y}), 0);
    reset = 1'b0;
    cyc = 0;
    prev_hs = 1'b0;
    prev_vs = 1'b0;
    req_q = 1'b0;
    req_idx = 0;
    clear_stats();
    step(1, 1'b0);
    check("rerelease_frame_start", frame_start, 1);
    check("rerelease_hsync", hsync, 1);
    step(3 * LINE_CLKS, 1'b0);
    check("rerelease_hsync_period", hs_period, LINE_CLKS);
    check("rerelease_hsync_width", hs_width, 8);
    check("rerelease_vsync_edges", vedge_err, 0);
    check("rerelease_sync_errs", sync_err, 0);
    check("rerelease_de_errs", de_err, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
